risc_datapath: RTL and testbench

Single-bus 32-bit datapath for the RISC CPU: sixteen general registers, PC, MAR, MDR, HI, LO, Y, 64-bit Z and an ALU, all connected through one 32-bit bus multiplexer. It sits under the control unit, which drives every register-enable, bus-select, memory-read and ALU opcode line directly, one microstep per clock. No instruction decode is done here; the control unit fully sequences the block.

---
 rtl/risc_datapath.sv | 164 ++++++++++++++++
 tb/tb_risc_datapath.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_datapath.sv
// risc_datapath -- single-bus 32-bit datapath for the RISC CPU.
//
// Sixteen general registers, PC, MAR, MDR, HI, LO, Y, a 64-bit Z and an ALU,
// all joined by one combinational 32-bit bus multiplexer. The control unit
// drives every enable, bus select and the ALU opcode directly, one microstep
// per clock.
//
// Ports:
//   Clock        rising-edge clock for every register
//   clear        asynchronous active-low reset (all registers to 0)
//   Mdatain      memory read data, loaded into MDR when Read = 1
//   Read         MDR source: 1 = Mdatain, 0 = bus
//   IncPC        force ALU to bus + 1
//   Rin/Rout     per-register load enable / bus drive (bit i = Ri)
//   PCin, Zin, MDRin, MARin, Yin, HIin, LOin            load enables
//   PCout, Zhighout, Zlowout, HIout, LOout, MDRout,
//   InPortout                                           bus drive selects
//   opcode       ALU operation
//   BusMuxOut    current bus value
//
// Configuration macro: DATAPATH_MULDIV_EN -- when defined, opcodes 01111 (mul)
// and 10000 (div) are implemented; otherwise they yield Z = 0 and no
// multiplier or divider is built.

module risc_datapath (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic        Read,
    input  logic        IncPC,
    input  logic [15:0] Rin,
    input  logic [15:0] Rout,
    input  logic        PCin,
    input  logic        Zin,
    input  logic        MDRin,
    input  logic        MARin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        MDRout,
    input  logic        InPortout,
    input  logic [4:0]  opcode,
    output logic [31:0] BusMuxOut
);

    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [63:0] z_q, z_d;
    logic [31:0] bus;
    logic [63:0] alu_res;
    logic [4:0]  amt;
    logic [63:0] rot_r, rot_l;

    // MAR feeds the memory address in the full CPU; this block has no
    // address port, so it is only stored here.
    logic unused_mar;
    assign unused_mar = ^mar_q;

    // Bus mux: assignments run from lowest to highest priority so the
    // last matching select wins; Rout loop counts down so R0 wins.
    always_comb begin
        bus = '0;
        if (InPortout) bus = '0;   // input port reserved, drives zero
        if (MDRout)    bus = mdr_q;
        if (PCout)     bus = pc_q;
        if (Zlowout)   bus = z_q[31:0];
        if (Zhighout)  bus = z_q[63:32];
        if (LOout)     bus = lo_q;
        if (HIout)     bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (Rout[i]) bus = r_q[i];
        end
    end

    assign BusMuxOut = bus;

`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] a_sx, b_sx, div_b, prod;
    logic [31:0]        quot, rem;

    // 64-bit signed operands keep -2^31 / -1 well defined.
    always_comb begin
        a_sx  = {{32{y_q[31]}}, y_q};
        b_sx  = {{32{bus[31]}}, bus};
        div_b = (bus == '0) ? 64'sd1 : b_sx;
        prod  = a_sx * b_sx;
        quot  = 32'(a_sx / div_b);
        rem   = 32'(a_sx % div_b);
    end
`endif

    // ALU: A = Y, B = bus. Rotates come from the doubled word shifted.
    always_comb begin
        amt     = bus[4:0];
        rot_r   = {y_q, y_q} >> amt;
        rot_l   = {y_q, y_q} << amt;
        alu_res = '0;
        if (IncPC) begin
            alu_res = {32'h0, bus + 32'd1};
        end else begin
            case (opcode)
                5'b00011, 5'b01100: alu_res = {32'h0, y_q + bus};
                5'b00100:           alu_res = {32'h0, y_q - bus};
                5'b01010, 5'b01101: alu_res = {32'h0, y_q & bus};
                5'b01011, 5'b01110: alu_res = {32'h0, y_q | bus};
                5'b00101:           alu_res = {32'h0, y_q >> amt};
                5'b00110:           alu_res = {32'h0, 32'($signed(y_q) >>> amt)};
                5'b00111:           alu_res = {32'h0, y_q << amt};
                5'b01000:           alu_res = {32'h0, rot_r[31:0]};
                5'b01001:           alu_res = {32'h0, rot_l[63:32]};
                5'b10001:           alu_res = {32'h0, -bus};
                5'b10010:           alu_res = {32'h0, ~bus};
`ifdef DATAPATH_MULDIV_EN
                5'b01111:           alu_res = prod;
                5'b10000:           alu_res = (bus == '0) ? 64'h0 : {rem, quot};
`endif
                default:            alu_res = '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = Rin[i] ? bus : r_q[i];
        end
        pc_d  = PCin  ? bus : pc_q;
        mar_d = MARin ? bus : mar_q;
        mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = LOin  ? bus : lo_q;
        y_d   = Yin   ? bus : y_q;
        z_d   = Zin   ? alu_res : z_q;
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            pc_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

endmodule

// File: tb/tb_risc_datapath.sv
// Testbench for risc_datapath: directed microstep sequences followed by
// random microsteps, every bus value compared against a behavioural model.

module tb_risc_datapath;

    logic        Clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        Read, IncPC;
    logic [15:0] Rin, Rout;
    logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
    logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout;
    logic [4:0]  opcode;
    logic [31:0] BusMuxOut;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] mr [16];
    logic [31:0] mpc, mmdr, mhi, mlo, my;
    logic [63:0] mz;

    always #5 Clock = ~Clock;

    risc_datapath dut (
        .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
        .IncPC(IncPC), .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin),
        .MDRin(MDRin), .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .MDRout(MDRout),
        .InPortout(InPortout), .opcode(opcode), .BusMuxOut(BusMuxOut)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Read = 0; IncPC = 0; Rin = '0; Rout = '0;
        PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
        PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0;
        MDRout = 0; InPortout = 0; opcode = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = '0;
        mpc = '0; mmdr = '0; mhi = '0; mlo = '0; my = '0; mz = '0;
    endtask

    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 16; i++) if (Rout[i]) return mr[i];
        if (HIout)    return mhi;
        if (LOout)    return mlo;
        if (Zhighout) return mz[63:32];
        if (Zlowout)  return mz[31:0];
        if (PCout)    return mpc;
        if (MDRout)   return mmdr;
        return 32'h0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic inc);
        int          ia, ib;
        longint      la, lb;
        logic [63:0] q, r;
        logic [31:0] res;
        int unsigned sh;
        ia = a; ib = b; la = ia; lb = ib;
        sh = b[4:0];
        res = '0;
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            5'd3, 5'd12:  res = a + b;
            5'd4:         res = a - b;
            5'd10, 5'd13: res = a & b;
            5'd11, 5'd14: res = a | b;
            5'd5:         res = a >> sh;
            5'd6:         res = ia >>> sh;
            5'd7:         res = a << sh;
            5'd8:         res = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
            5'd9:         res = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
            5'd17:        res = 32'h0 - b;
            5'd18:        res = ~b;
`ifdef DATAPATH_MULDIV_EN
            5'd15: return la * lb;
            5'd16: begin
                if (b == 0) return 64'h0;
                q = la / lb;
                r = la % lb;
                return {r[31:0], q[31:0]};
            end
`endif
            default: res = '0;
        endcase
        return {32'h0, res};
    endfunction

    // One microstep: called just after a falling edge with controls set.
    task automatic tick();
        logic [31:0] b;
        #1;
        b = model_bus();
        chk("bus", BusMuxOut, b);
        if (Zin) mz = model_alu(opcode, my, b, IncPC);
        for (int i = 0; i < 16; i++) if (Rin[i]) mr[i] = b;
        if (PCin)  mpc  = b;
        if (MDRin) mmdr = Read ? Mdatain : b;
        if (HIin)  mhi  = b;
        if (LOin)  mlo  = b;
        if (Yin)   my   = b;
        @(negedge Clock);
        idle();
    endtask

    task automatic peek(input string tag, input logic [31:0] exp);
        #1 chk(tag, BusMuxOut, exp);
        tick();
    endtask

    // dest: 0-15 Ri, 16 Y, 17 PC, 18 HI, 19 LO
    task automatic put(input logic [31:0] v, input int dest);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
        MDRout = 1;
        if (dest < 16)       Rin[dest] = 1'b1;
        else if (dest == 16) Yin = 1;
        else if (dest == 17) PCin = 1;
        else if (dest == 18) HIin = 1;
        else                 LOin = 1;
        tick();
    endtask

    task automatic run_op(input logic [4:0] op, input logic [15:0] src);
        Rout = src; opcode = op; Zin = 1;
        tick();
    endtask

    initial begin
        logic [31:0] mul_lo, mul_hi, div_lo, div_hi;
        int k;
`ifdef DATAPATH_MULDIV_EN
        mul_lo = 32'hFFFFFFEB; mul_hi = 32'hFFFFFFFF;
        div_lo = 32'hFFFFFFFD; div_hi = 32'hFFFFFFFF;
`else
        mul_lo = 32'h0; mul_hi = 32'h0; div_lo = 32'h0; div_hi = 32'h0;
`endif
        idle();
        Mdatain = '0;
        clear = 0;
        model_reset();
        #2 chk("rst_bus", BusMuxOut, 32'h0);
        @(negedge Clock);
        clear = 1;

        // load and NOT
        put(32'h12, 0);
        put(32'h14, 1);
        Rout = 16'h0001; peek("r0_load", 32'h12);
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; peek("pc_bus", 32'h0);
        Zlowout = 1; peek("inc_zlo", 32'h1);
        run_op(5'b10010, 16'h0002);
        Zlowout = 1; Rin = 16'h0001; tick();
        Rout = 16'h0001; peek("not_r0", 32'hFFFFFFEB);

        // add with wrap
        put(32'd5, 16);
        put(32'hFFFFFFFF, 2);
        run_op(5'b00011, 16'h0004);
        Zlowout = 1;  peek("add_lo", 32'h4);
        Zhighout = 1; peek("add_hi", 32'h0);

        // mul
        put(32'hFFFFFFFD, 16);
        put(32'd7, 3);
        run_op(5'b01111, 16'h0008);
        Zlowout = 1;  peek("mul_lo", mul_lo);
        Zhighout = 1; peek("mul_hi", mul_hi);

        // div -7 / 2
        put(32'hFFFFFFF9, 16);
        put(32'd2, 4);
        run_op(5'b10000, 16'h0010);
        Zlowout = 1;  peek("div_lo", div_lo);
        Zhighout = 1; peek("div_hi", div_hi);

        // div by zero: no select, bus = 0
        put(32'd9, 16);
        run_op(5'b10000, 16'h0000);
        Zlowout = 1;  peek("div0_lo", 32'h0);
        Zhighout = 1; peek("div0_hi", 32'h0);

        // ror
        put(32'h80000001, 16);
        put(32'd4, 5);
        run_op(5'b01000, 16'h0020);
        Zlowout = 1; peek("ror", 32'h18000000);

        // bus priority and idle bus
        Rout = 16'h0008; MDRout = 1; peek("prio", 32'd7);
        peek("nosel", 32'h0);

        // asynchronous reset mid-cycle
        put(32'hDEADBEEF, 6);
        #2 clear = 0;
        model_reset();
        Rout = 16'h0040;
        #1 chk("rst_r6", BusMuxOut, 32'h0);
        Rout = '0; Zlowout = 1;
        #1 chk("rst_z", BusMuxOut, 32'h0);
        Zlowout = 0;
        @(negedge Clock);
        clear = 1;
        idle();
        put(32'h55, 7);
        Rout = 16'h0080; peek("post_rst", 32'h55);

        // random microsteps
        repeat (400) begin
            Mdatain = $urandom;
            Read    = 1'($urandom);
            Rin     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            k = $urandom_range(0, 22);
            if (k < 16)       Rout[k] = 1'b1;
            else if (k == 16) HIout = 1;
            else if (k == 17) LOout = 1;
            else if (k == 18) Zhighout = 1;
            else if (k == 19) Zlowout = 1;
            else if (k == 20) PCout = 1;
            else if (k == 21) MDRout = 1;
            else              InPortout = 1;
            if ($urandom_range(0, 3) == 0) MDRout = 1;
            if ($urandom_range(0, 5) == 0) Rout = Rout | 16'($urandom);
            PCin  = ($urandom_range(0, 3) == 0);
            Zin   = ($urandom_range(0, 2) == 0);
            MDRin = ($urandom_range(0, 3) == 0);
            MARin = ($urandom_range(0, 3) == 0);
            Yin   = ($urandom_range(0, 2) == 0);
            HIin  = ($urandom_range(0, 4) == 0);
            LOin  = ($urandom_range(0, 4) == 0);
            IncPC = ($urandom_range(0, 7) == 0);
            opcode = 5'($urandom_range(0, 19));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
